// File: rtl/sync_tx_defs.sv
// Shared definitions for the K/J sync-link transmitter: FSM states, line
// encodings and the sync pattern.
package sync_tx_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_STUFF,
        ST_EOP,
        ST_EOPJ
    } state_t;

    // Line states packed as {k, j}; {1,1} is never driven.
    localparam logic [1:0] LINE_J   = 2'b01;
    localparam logic [1:0] LINE_K   = 2'b10;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // NRZI level 0 is J, level 1 is K.
    function automatic logic [1:0] level_to_line(input logic level);
        return level ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/nrzi_stuffer.sv
// NRZI encoder with bit stuffing: holds the line level and the run of
// consecutive ones, and flags when the current bit completes a stuffing run.
module nrzi_stuffer #(
    parameter int STUFF_LEN = 6
) (
    input  logic CLK,
    input  logic RST,
    input  logic tx_bit,
    input  logic bit_valid,
    input  logic force_stuff,
    input  logic init,
    output logic level,
    output logic need_stuff
);

    localparam int OW = $clog2(STUFF_LEN + 1);

    logic          level_reg;
    logic [OW-1:0] ones_reg;
    logic          is_zero;

    // level is the line level shown this cycle; it becomes the stored level at the edge.
    always_comb begin
        is_zero    = force_stuff || (bit_valid && !tx_bit);
        level      = is_zero ? ~level_reg : level_reg;
        need_stuff = bit_valid && tx_bit && (ones_reg == OW'(STUFF_LEN - 1));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            level_reg <= 1'b0;
            ones_reg  <= '0;
        end else if (init) begin
            level_reg <= 1'b0;
            ones_reg  <= '0;
        end else begin
            level_reg <= level;
            if (is_zero)
                ones_reg <= '0;
            else if (bit_valid)
                ones_reg <= ones_reg + OW'(1);
        end
    end

endmodule

// File: rtl/sync_tx.sv
// Transmit end of the K/J sync link: SYNC pattern, NRZI/stuffed payload
// bytes fetched over valid/ready, then SE0 end-of-packet and a closing J.
module sync_tx #(
    parameter int STUFF_LEN = 6,
    parameter int EOP_LEN   = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       k,
    output logic       j,
    output logic       tx_en,
    output logic       busy,
    output logic       tx_done
);

    import sync_tx_defs::*;

    localparam int EW = (EOP_LEN > 1) ? $clog2(EOP_LEN) : 1;

    state_t        state_reg, state_next;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    data_reg;
    logic [EW-1:0] eop_cnt_reg;
    logic          end_reg;
    logic          armed_reg;

    logic       cur_bit, bit_valid, byte_end, force_stuff, init;
    logic       level, need_stuff;
    logic [1:0] line;

    nrzi_stuffer #(.STUFF_LEN(STUFF_LEN)) u_stuffer (
        .CLK        (CLK),
        .RST        (RST),
        .tx_bit     (cur_bit),
        .bit_valid  (bit_valid),
        .force_stuff(force_stuff),
        .init       (init),
        .level      (level),
        .need_stuff (need_stuff)
    );

    always_comb begin
        bit_valid   = (state_reg == ST_SYNC) || (state_reg == ST_DATA);
        force_stuff = (state_reg == ST_STUFF);
        init        = (state_reg == ST_IDLE);
        cur_bit     = (state_reg == ST_SYNC) ? SYNC_BYTE[bit_cnt_reg] : data_reg[bit_cnt_reg];
        byte_end    = bit_valid && (bit_cnt_reg == 3'd7);
        data_ready  = byte_end && data_valid;

        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (tx_start && armed_reg) state_next = ST_SYNC;
            ST_SYNC,
            ST_DATA: begin
                // A pending stuff always goes first; end_reg remembers the fetch outcome.
                if (need_stuff)
                    state_next = ST_STUFF;
                else if (byte_end)
                    state_next = data_valid ? ST_DATA : ST_EOP;
            end
            ST_STUFF: state_next = end_reg ? ST_EOP : ST_DATA;
            ST_EOP:   if (eop_cnt_reg == EW'(EOP_LEN - 1)) state_next = ST_EOPJ;
            ST_EOPJ:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        line = LINE_J;
        case (state_reg)
            ST_SYNC, ST_DATA, ST_STUFF: line = level_to_line(level);
            ST_EOP:                     line = LINE_SE0;
            default:                    line = LINE_J;
        endcase
        k       = line[1];
        j       = line[0];
        tx_en   = (state_reg != ST_IDLE);
        busy    = (state_reg != ST_IDLE);
        tx_done = (state_reg == ST_EOPJ);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            data_reg    <= '0;
            eop_cnt_reg <= '0;
            end_reg     <= 1'b0;
            armed_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Blocks a start request sampled on the first edge after reset release.
            armed_reg <= 1'b1;
            if (state_reg == ST_IDLE)
                bit_cnt_reg <= '0;
            else if (bit_valid)
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (data_ready)
                data_reg <= data_in;
            if (byte_end)
                end_reg <= !data_valid;
            eop_cnt_reg <= (state_reg == ST_EOP) ? eop_cnt_reg + EW'(1) : '0;
        end
    end

endmodule

// File: tb/tb_sync_tx.sv
// Directed bench for sync_tx: table of whole packets with hand-computed line
// sequences, plus reset and start-request corner sequences.
module tb_sync_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       tx_start;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready, k, j, tx_en, busy, tx_done;

    int checks   = 0;
    int failures = 0;

    sync_tx dut (
        .CLK       (CLK),
        .RST       (RST),
        .tx_start  (tx_start),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .k         (k),
        .j         (j),
        .tx_en     (tx_en),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          nbytes;
        logic [7:0]  b0;
        logic [7:0]  b1;
        bit          poke;
        string       lines;
        int          en_len;
        logic [63:0] ready_mask;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                input bit poke, input string l, input int len,
                                input logic [63:0] m);
        vec_t v;
        v.nbytes = n; v.b0 = b0; v.b1 = b1; v.poke = poke;
        v.lines = l; v.en_len = len; v.ready_mask = m;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    function automatic string line_char();
        if (k && j) return "X";
        if (k)      return "K";
        if (j)      return "J";
        return "0";
    endfunction

    task automatic run_vec(input int vi);
        vec_t        v;
        logic [7:0]  bytes[2];
        int          idx, en_n, done_n, done_at;
        string       got;
        logic [63:0] rmask;
        v = vecs[vi];
        bytes[0] = v.b0; bytes[1] = v.b1;
        idx = 0; en_n = 0; done_n = 0; done_at = 0; got = ""; rmask = '0;
        @(posedge CLK); #1;
        tx_start = 1'b1; data_valid = 1'b0;
        @(posedge CLK); #1;
        tx_start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tx_start   = v.poke && (c == 3 || c == 9);
            data_valid = (idx < v.nbytes);
            data_in    = (idx < 2) ? bytes[idx] : 8'h00;
            @(negedge CLK);
            if (tx_en) begin
                got = {got, line_char()};
                en_n++;
            end
            if (data_ready) begin
                rmask[c] = 1'b1;
                idx++;
            end
            if (tx_done) begin
                done_n++;
                done_at = c;
            end
            @(posedge CLK); #1;
        end
        tx_start = 1'b0; data_valid = 1'b0;
        chk_s($sformatf("v%0d lines", vi), got, v.lines);
        chk($sformatf("v%0d tx_en_cycles", vi), 64'(en_n), 64'(v.en_len));
        chk($sformatf("v%0d ready_cycles", vi), rmask, v.ready_mask);
        chk($sformatf("v%0d done_count", vi), 64'(done_n), 64'd1);
        chk($sformatf("v%0d done_cycle", vi), 64'(done_at), 64'(v.en_len));
        chk($sformatf("v%0d busy_after", vi), 64'(busy), 64'd0);
        $display("vec %0d: n=%0d lines=%s en=%0d ready=%0h done@%0d", vi, v.nbytes, got, en_n, rmask, done_at);
    endtask

    initial begin
        vecs[0] = mk(0, 8'h00, 8'h00, 1'b0, "KJKJKJKK00J", 11, 64'h0);
        vecs[1] = mk(1, 8'h00, 8'h00, 1'b0, "KJKJKJKKJKJKJKJK00J", 19, 64'h100);
        vecs[2] = mk(1, 8'hFF, 8'h00, 1'b0, "KJKJKJKKKKKKKJJJJ00J", 20, 64'h100);
        vecs[3] = mk(2, 8'hA5, 8'h3C, 1'b0, "KJKJKJKKKJJKJJKKJKKKKKJK00J", 27, 64'h10100);
        vecs[4] = mk(2, 8'hFF, 8'hFF, 1'b0, "KJKJKJKKKKKKKJJJJJJJKKKKKK00J", 29, 64'h20100);
        vecs[5] = mk(1, 8'hFC, 8'h00, 1'b0, "KJKJKJKKJKKKKKKKJ00J", 20, 64'h100);
        vecs[6] = mk(0, 8'h00, 8'h00, 1'b1, "KJKJKJKK00J", 11, 64'h0);

        RST = 1'b0; tx_start = 1'b0; data_valid = 1'b1; data_in = 8'h00;
        repeat (3) @(negedge CLK);
        chk("rst k", 64'(k), 64'd0);
        chk("rst j", 64'(j), 64'd1);
        chk("rst tx_en", 64'(tx_en), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst data_ready", 64'(data_ready), 64'd0);
        chk("rst tx_done", 64'(tx_done), 64'd0);
        $display("reset: k=%0b j=%0b tx_en=%0b busy=%0b", k, j, tx_en, busy);

        // Start request coinciding with reset release must be ignored.
        RST = 1'b1; tx_start = 1'b1; data_valid = 1'b0;
        @(posedge CLK); #1;
        tx_start = 1'b0;
        @(negedge CLK);
        chk("release_start busy", 64'(busy), 64'd0);
        chk("release_start tx_en", 64'(tx_en), 64'd0);
        $display("release+start: busy=%0b tx_en=%0b", busy, tx_en);

        for (int vi = 0; vi < 7; vi++)
            run_vec(vi);

        // Reset in the middle of DATA bit 3 of byte A5.
        @(posedge CLK); #1;
        tx_start = 1'b1; data_valid = 1'b1; data_in = 8'hA5;
        @(posedge CLK); #1;
        tx_start = 1'b0;
        repeat (11) begin
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        chk("mid_data line", 64'(line_char() == "K"), 64'd1);
        RST = 1'b0;
        #1;
        chk("mid_rst k", 64'(k), 64'd0);
        chk("mid_rst j", 64'(j), 64'd1);
        chk("mid_rst tx_en", 64'(tx_en), 64'd0);
        chk("mid_rst busy", 64'(busy), 64'd0);
        data_valid = 1'b0;
        $display("mid-data reset: k=%0b j=%0b tx_en=%0b busy=%0b", k, j, tx_en, busy);
        repeat (2) begin
            @(negedge CLK);
            chk("mid_rst no_eop", 64'(tx_en), 64'd0);
        end
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("post_rst idle j", 64'(j & ~k), 64'd1);
        chk("post_rst tx_en", 64'(tx_en), 64'd0);
        run_vec(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
